// File: rtl/pixel_generator.sv
// Synthetic RGB888 video source: packs 4 pixels into 3 32-bit AXI4-Stream words,
// flags start-of-frame on tuser and end-of-line on tlast, and exposes a small
// AXI4-Lite register bank (REG0[7:0] selects the blue level, latched per frame).
module pixel_generator #(
    parameter int X_PIXELS  = 200,
    parameter int Y_LINES   = 200,
    parameter int REG_COUNT = 8
) (
    input  logic        out_stream_aclk,
    input  logic        s_axi_lite_aclk,
    input  logic        axi_resetn,
    input  logic        periph_resetn,

    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,

    input  logic [7:0]  s_axi_lite_awaddr,
    input  logic        s_axi_lite_awvalid,
    output logic        s_axi_lite_awready,
    input  logic [31:0] s_axi_lite_wdata,
    input  logic        s_axi_lite_wvalid,
    output logic        s_axi_lite_wready,
    output logic [1:0]  s_axi_lite_bresp,
    output logic        s_axi_lite_bvalid,
    input  logic        s_axi_lite_bready,
    input  logic [7:0]  s_axi_lite_araddr,
    input  logic        s_axi_lite_arvalid,
    output logic        s_axi_lite_arready,
    output logic [31:0] s_axi_lite_rdata,
    output logic [1:0]  s_axi_lite_rresp,
    output logic        s_axi_lite_rvalid,
    input  logic        s_axi_lite_rready
);

    localparam int WPL = X_PIXELS * 3 / 4;
    localparam int IW  = $clog2(REG_COUNT);

    // Both reset inputs are active-high despite their names; either one resets the block.
    logic rst;
    assign rst = axi_resetn | periph_resetn;

    // The AXI-Lite clock input is the same net as the stream clock; it is not used here.
    logic unused_ok;
    assign unused_ok = ^{s_axi_lite_aclk, s_axi_lite_awaddr, s_axi_lite_araddr};

    logic [31:0] regs [REG_COUNT];

    // Stream state: counters describe the word that will be loaded next.
    logic [15:0] x_cnt;
    logic [15:0] y_cnt;
    logic [15:0] base_px;
    logic [1:0]  phase;
    logic [7:0]  blue_frame;

    logic [31:0] data_p0;
    logic        vld_p0;
    logic        last_p0;
    logic        user_p0;

    logic        load;
    logic        first_word;
    logic        last_word;
    logic [7:0]  blue_cur;

    // Pack one word of the R,G,B byte stream; px is the x-coordinate of the group's first pixel.
    function automatic logic [31:0] pack_word(input logic [1:0] ph, input logic [7:0] px,
                                              input logic [7:0] g, input logic [7:0] b);
        logic [7:0] r0, r1, r2, r3;
        logic [31:0] w;
        r0 = px;
        r1 = px + 8'd1;
        r2 = px + 8'd2;
        r3 = px + 8'd3;
        case (ph)
            2'd0:    w = {r1, b, g, r0};
            2'd1:    w = {g, r2, b, g};
            default: w = {b, g, r3, b};
        endcase
        return w;
    endfunction

    assign load       = !vld_p0 || out_stream_tready;
    assign first_word = (x_cnt == 16'd0) && (y_cnt == 16'd0);
    assign last_word  = (x_cnt == 16'(WPL - 1));
    // The start-of-frame word already uses the freshly sampled blue value.
    assign blue_cur   = first_word ? regs[0][7:0] : blue_frame;

    // Output word register and raster counters; advance only when the slot is free.
    always_ff @(posedge out_stream_aclk) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            data_p0    <= '0;
            last_p0    <= 1'b0;
            user_p0    <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            base_px    <= '0;
            phase      <= '0;
            blue_frame <= '0;
        end else if (load) begin
            vld_p0  <= 1'b1;
            data_p0 <= pack_word(phase, base_px[7:0], y_cnt[7:0], blue_cur);
            last_p0 <= last_word;
            user_p0 <= first_word;
            if (first_word) begin
                blue_frame <= regs[0][7:0];
            end
            if (last_word) begin
                x_cnt   <= '0;
                phase   <= '0;
                base_px <= '0;
                y_cnt   <= (y_cnt == 16'(Y_LINES - 1)) ? 16'd0 : y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
                if (phase == 2'd2) begin
                    phase   <= '0;
                    base_px <= base_px + 16'd4;
                end else begin
                    phase <= phase + 2'd1;
                end
            end
        end
    end

    assign out_stream_tdata  = data_p0;
    assign out_stream_tvalid = vld_p0;
    assign out_stream_tlast  = last_p0;
    assign out_stream_tuser  = user_p0;
    assign out_stream_tkeep  = 4'hF;

    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;
    assign widx = s_axi_lite_awaddr[IW+1:2];
    assign ridx = s_axi_lite_araddr[IW+1:2];

    // Write channel: one-cycle ready pulse, register update on the handshake, hold bvalid until bready.
    always_ff @(posedge out_stream_aclk) begin
        if (rst) begin
            s_axi_lite_awready <= 1'b0;
            s_axi_lite_wready  <= 1'b0;
            s_axi_lite_bvalid  <= 1'b0;
            s_axi_lite_bresp   <= 2'b00;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (!s_axi_lite_awready && !s_axi_lite_bvalid &&
                s_axi_lite_awvalid && s_axi_lite_wvalid) begin
                s_axi_lite_awready <= 1'b1;
                s_axi_lite_wready  <= 1'b1;
            end else begin
                s_axi_lite_awready <= 1'b0;
                s_axi_lite_wready  <= 1'b0;
            end
            if (s_axi_lite_awready && s_axi_lite_awvalid && s_axi_lite_wvalid) begin
                regs[widx]        <= s_axi_lite_wdata;
                s_axi_lite_bvalid <= 1'b1;
                s_axi_lite_bresp  <= 2'b00;
            end else if (s_axi_lite_bvalid && s_axi_lite_bready) begin
                s_axi_lite_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: one-cycle arready pulse, data captured on the handshake (pre-write value).
    always_ff @(posedge out_stream_aclk) begin
        if (rst) begin
            s_axi_lite_arready <= 1'b0;
            s_axi_lite_rvalid  <= 1'b0;
            s_axi_lite_rdata   <= '0;
            s_axi_lite_rresp   <= 2'b00;
        end else begin
            s_axi_lite_arready <= !s_axi_lite_arready && !s_axi_lite_rvalid && s_axi_lite_arvalid;
            if (s_axi_lite_arready && s_axi_lite_arvalid) begin
                s_axi_lite_rdata  <= regs[ridx];
                s_axi_lite_rvalid <= 1'b1;
                s_axi_lite_rresp  <= 2'b00;
            end else if (s_axi_lite_rvalid && s_axi_lite_rready) begin
                s_axi_lite_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_generator.sv
// Testbench for pixel_generator: random backpressure against a byte-stream
// reference model, plus directed AXI-Lite accesses and mid-frame reset.
module tb_pixel_generator;

    localparam int XP    = 200;
    localparam int YL    = 200;
    localparam int WPL   = XP * 3 / 4;
    localparam int FRAME = WPL * YL;

    logic        clk = 1'b0;
    logic        axi_resetn, periph_resetn;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tuser, tvalid, tready;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    pixel_generator #(.X_PIXELS(XP), .Y_LINES(YL), .REG_COUNT(8)) dut (
        .out_stream_aclk(clk), .s_axi_lite_aclk(clk),
        .axi_resetn(axi_resetn), .periph_resetn(periph_resetn),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
        .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
        .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
        .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
        .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
        .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
        .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
        .s_axi_lite_rready(rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: index of the word currently presented within the frame.
    logic        m_valid;
    int          m_idx;
    logic [7:0]  m_blue;
    logic [31:0] m_reg0;
    int          mode;   // 0 random tready, 1 always ready, 2 stalled

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word n of a frame is bytes 4n..4n+3 of the R,G,B,R,G,B,... byte stream of its line.
    function automatic logic [31:0] exp_word(input int idx, input logic [7:0] blue);
        int x, y, b, pix;
        logic [31:0] w;
        x = idx % WPL;
        y = idx / WPL;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            b   = 4 * x + k;
            pix = b / 3;
            case (b % 3)
                0:       w[8*k +: 8] = pix[7:0];
                1:       w[8*k +: 8] = y[7:0];
                default: w[8*k +: 8] = blue;
            endcase
        end
        return w;
    endfunction

    // One clock: check presented outputs, choose tready, advance the model over the edge.
    task automatic step();
        if (m_valid) begin
            chk("tvalid", {31'd0, tvalid}, 32'd1);
            chk("tdata", tdata, exp_word(m_idx, m_blue));
            chk("tuser", {31'd0, tuser}, {31'd0, m_idx == 0});
            chk("tlast", {31'd0, tlast}, {31'd0, (m_idx % WPL) == WPL - 1});
            chk("tkeep", {28'd0, tkeep}, 32'hF);
        end else begin
            chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
            chk("rst_tdata", tdata, 32'd0);
            chk("rst_tuser", {31'd0, tuser}, 32'd0);
            chk("rst_tlast", {31'd0, tlast}, 32'd0);
        end
        case (mode)
            0:       tready = ($urandom_range(0, 3) != 0);
            1:       tready = 1'b1;
            default: tready = 1'b0;
        endcase
        @(posedge clk);
        if (axi_resetn || periph_resetn) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_blue  = 8'd0;
            m_reg0  = 32'd0;
        end else begin
            if (m_valid && tready) m_idx = (m_idx + 1) % FRAME;
            if (!m_valid || tready) begin
                m_valid = 1'b1;
                if (m_idx == 0) m_blue = m_reg0[7:0];
            end
        end
        #1;
    endtask

    task automatic run_until(input int target);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 70000 && !hit; i++) begin
            if (m_valid && m_idx == target) hit = 1'b1;
            else step();
        end
        chk("reach_word", {31'd0, hit}, 32'd1);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data);
        logic ok;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (awready === 1'b1 && wready === 1'b1) ok = 1'b1;
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (ok && addr[4:2] == 3'd0) m_reg0 = data;
        chk("aw_handshake", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 20 && bvalid !== 1'b1; i++) step();
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_clr", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] exp);
        logic ok;
        araddr = addr; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (arready === 1'b1) ok = 1'b1;
            step();
        end
        arvalid = 1'b0;
        chk("ar_handshake", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 20 && rvalid !== 1'b1; i++) step();
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        chk("rdata", rdata, exp);
        chk("rresp", {30'd0, rresp}, 32'd0);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rvalid_clr", {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        axi_resetn = 1'b1; periph_resetn = 1'b0; tready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        m_valid = 1'b0; m_idx = 0; m_blue = 8'd0; m_reg0 = 32'd0; mode = 1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        step();
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        // Release: first word appears one edge later.
        axi_resetn = 1'b0;
        step();
        chk("first_tvalid", {31'd0, tvalid}, 32'd1);
        chk("first_tuser", {31'd0, tuser}, 32'd1);
        chk("first_tdata", tdata, 32'h01000000);

        // Long stall right after the first word.
        mode = 2;
        repeat (1000) step();
        chk("stall_tdata", tdata, 32'h01000000);
        mode = 1;
        run_until(WPL);

        // Line 5, words 0..2, blue still zero.
        mode = 0;
        run_until(5 * WPL);
        chk("line5_w0", tdata, 32'h01000500);
        run_until(5 * WPL + 1);
        chk("line5_w1", tdata, 32'h05020005);
        run_until(5 * WPL + 2);
        chk("line5_w2", tdata, 32'h00050300);

        // Mid-frame register traffic.
        run_until(5000);
        axi_write(8'h00, 32'h000000AB);
        axi_read(8'h00, 32'h000000AB);
        axi_read(8'h40, 32'h000000AB);
        axi_write(8'h2C, 32'h12345678);
        axi_read(8'h0C, 32'h12345678);

        // Simultaneous read and write of REG5: the read sees the old value.
        awaddr = 8'h14; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h14; arvalid = 1'b1;
        step();
        chk("rw_awready", {31'd0, awready}, 32'd1);
        chk("rw_arready", {31'd0, arready}, 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_bvalid", {31'd0, bvalid}, 32'd1);
        chk("rw_rvalid", {31'd0, rvalid}, 32'd1);
        chk("rw_old_data", rdata, 32'd0);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        axi_read(8'h14, 32'h00000055);

        // Blue stays 0 through this frame; next frame carries 0xAB.
        run_until(FRAME - 1);
        chk("frame0_last_tlast", {31'd0, tlast}, 32'd1);
        run_until(0);
        chk("frame1_first", tdata, 32'h01AB0000);
        chk("frame1_tuser", {31'd0, tuser}, 32'd1);

        // Reset mid-frame at line 50, word 70, via the second reset input.
        run_until(50 * WPL + 70);
        periph_resetn = 1'b1;
        repeat (3) step();
        chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("mid_rst_awready", {31'd0, awready}, 32'd0);
        periph_resetn = 1'b0;
        step();
        chk("post_rst_tuser", {31'd0, tuser}, 32'd1);
        chk("post_rst_tdata", tdata, 32'h01000000);
        axi_read(8'h00, 32'd0);
        run_until(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
